// File: rtl/sdram_apb_arbiter_pkg.sv
// Shared types and constants for the SDRAM APB two-port arbiter.
//   arb_state_t : arbiter FSM encoding
//   PORT_CPU    : requester index of the CPU load/store unit
//   PORT_DMA    : requester index of the DMA engine
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETUP  = 2'd1,
    ARB_ACCESS = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/sdram_apb_arbiter_rr.sv
// rr_arbiter2: stateless two-way round-robin picker.
//   req         : pending requests, bit 0 = CPU, bit 1 = DMA
//   last_grant  : port that completed the previous transfer
//   grant_valid : at least one request pending
//   grant_idx   : chosen port; on contention the port that was not last served
module rr_arbiter2
  import sdram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = PORT_CPU;
    case (req)
      2'b10:   grant_idx = PORT_DMA;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/sdram_apb_arbiter.sv
// sdram_apb_arbiter: shares the SDRAM wrapper APB slave port between the CPU
// LSU (port 0) and DMA (port 1). The winning request is captured into
// registers and replayed downstream as a SETUP/ACCESS transfer; the response
// is returned only to the granted requester.
//   clock, reset_n         : clock, asynchronous active-low reset
//   in0_* / in1_*          : upstream APB requester ports
//   out_paddr..out_pstrb   : registered request payload to the SDRAM wrapper
//   out_psel, out_penable  : downstream phase control (decoded from state)
//   out_pready/prdata/pslverr : downstream response
module sdram_apb_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,

  input  logic [ADDR_W-1:0]     in0_paddr,
  input  logic                  in0_psel,
  input  logic                  in0_penable,
  input  logic [2:0]            in0_pprot,
  input  logic                  in0_pwrite,
  input  logic [DATA_W-1:0]     in0_pwdata,
  input  logic [DATA_W/8-1:0]   in0_pstrb,
  output logic                  in0_pready,
  output logic [DATA_W-1:0]     in0_prdata,
  output logic                  in0_pslverr,

  input  logic [ADDR_W-1:0]     in1_paddr,
  input  logic                  in1_psel,
  input  logic                  in1_penable,
  input  logic [2:0]            in1_pprot,
  input  logic                  in1_pwrite,
  input  logic [DATA_W-1:0]     in1_pwdata,
  input  logic [DATA_W/8-1:0]   in1_pstrb,
  output logic                  in1_pready,
  output logic [DATA_W-1:0]     in1_prdata,
  output logic                  in1_pslverr,

  output logic [ADDR_W-1:0]     out_paddr,
  output logic [2:0]            out_pprot,
  output logic                  out_pwrite,
  output logic [DATA_W-1:0]     out_pwdata,
  output logic [DATA_W/8-1:0]   out_pstrb,
  output logic                  out_psel,
  output logic                  out_penable,
  input  logic                  out_pready,
  input  logic [DATA_W-1:0]     out_prdata,
  input  logic                  out_pslverr
);

  arb_state_t state, state_nxt;
  logic       last_grant;
  logic       grant;
  logic       pick_valid;
  logic       pick_idx;
  logic       capture;
  logic       complete;

  // penable from requesters plays no part in arbitration
  logic       unused_penable;
  assign unused_penable = in0_penable ^ in1_penable;

  rr_arbiter2 u_pick (
    .req         ({in1_psel, in0_psel}),
    .last_grant  (last_grant),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx)
  );

  // out_psel/out_penable decode straight from the state register so that an
  // asynchronous reset removes them immediately.
  always_comb begin
    state_nxt   = state;
    out_psel    = 1'b0;
    out_penable = 1'b0;
    capture     = 1'b0;
    complete    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          capture   = 1'b1;
          state_nxt = ARB_SETUP;
        end
      end
      ARB_SETUP: begin
        out_psel  = 1'b1;
        state_nxt = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        out_psel    = 1'b1;
        out_penable = 1'b1;
        if (out_pready) begin
          complete  = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB_IDLE;
      last_grant <= PORT_DMA;
      grant      <= PORT_CPU;
    end else begin
      state <= state_nxt;
      if (capture)  grant      <= pick_idx;
      if (complete) last_grant <= grant;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_paddr  <= '0;
      out_pprot  <= '0;
      out_pwrite <= 1'b0;
      out_pwdata <= '0;
      out_pstrb  <= '0;
    end else if (capture) begin
      out_paddr  <= (pick_idx == PORT_DMA) ? in1_paddr  : in0_paddr;
      out_pprot  <= (pick_idx == PORT_DMA) ? in1_pprot  : in0_pprot;
      out_pwrite <= (pick_idx == PORT_DMA) ? in1_pwrite : in0_pwrite;
      out_pwdata <= (pick_idx == PORT_DMA) ? in1_pwdata : in0_pwdata;
      out_pstrb  <= (pick_idx == PORT_DMA) ? in1_pstrb  : in0_pstrb;
    end
  end

  // A granted requester that has dropped psel no longer owns the response,
  // so the completion is swallowed rather than reported to it.
  always_comb begin
    in0_pready  = complete && (grant == PORT_CPU) && in0_psel;
    in1_pready  = complete && (grant == PORT_DMA) && in1_psel;
    in0_pslverr = in0_pready && out_pslverr;
    in1_pslverr = in1_pready && out_pslverr;
    in0_prdata  = out_prdata;
    in1_prdata  = out_prdata;
  end

endmodule

// File: tb/tb_sdram_apb_arbiter.sv
module tb_sdram_apb_arbiter;
  import sdram_arb_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] paddr  [2];
  logic [2:0]  pprot  [2];
  logic [31:0] pwdata [2];
  logic [3:0]  pstrb  [2];
  logic [31:0] prdata [2];
  logic [1:0]  psel, penable, pwrite, pready, pslverr;

  logic [31:0] out_paddr, out_pwdata;
  logic [2:0]  out_pprot;
  logic [3:0]  out_pstrb;
  logic        out_pwrite, out_psel, out_penable;
  logic        out_pready = 1'b0;
  logic        out_pslverr = 1'b0;
  logic [31:0] out_prdata = '0;

  sdram_apb_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .in0_paddr(paddr[0]), .in0_psel(psel[0]), .in0_penable(penable[0]),
    .in0_pprot(pprot[0]), .in0_pwrite(pwrite[0]), .in0_pwdata(pwdata[0]),
    .in0_pstrb(pstrb[0]), .in0_pready(pready[0]), .in0_prdata(prdata[0]),
    .in0_pslverr(pslverr[0]),
    .in1_paddr(paddr[1]), .in1_psel(psel[1]), .in1_penable(penable[1]),
    .in1_pprot(pprot[1]), .in1_pwrite(pwrite[1]), .in1_pwdata(pwdata[1]),
    .in1_pstrb(pstrb[1]), .in1_pready(pready[1]), .in1_prdata(prdata[1]),
    .in1_pslverr(pslverr[1]),
    .out_paddr(out_paddr), .out_pprot(out_pprot), .out_pwrite(out_pwrite),
    .out_pwdata(out_pwdata), .out_pstrb(out_pstrb), .out_psel(out_psel),
    .out_penable(out_penable), .out_pready(out_pready),
    .out_prdata(out_prdata), .out_pslverr(out_pslverr)
  );

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [2:0]  prot;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n_done = 0;
  int unsigned idle_run = 0;
  int unsigned wcnt = 0;
  bit          gap_chk = 1'b0;
  bit          gap_armed = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] prot_of(input int p);
    return (p == 1) ? 3'b010 : 3'b001;
  endfunction

  function automatic void push(input int p, input logic [31:0] a, input logic wr,
                               input logic [31:0] wd, input logic [3:0] st,
                               input logic [31:0] rd, input logic err, input int w);
    exp_t e;
    e.port = p; e.addr = a; e.prot = prot_of(p); e.wr = wr; e.wdata = wd;
    e.strb = st; e.rdata = rd; e.err = err; e.waits = w;
    sb.push_back(e);
  endfunction

  // Requester: called aligned 2 time units after a rising edge; returns the
  // same way. psel is held across back-to-back calls unless last is set.
  task automatic apb_req(input int p, input logic [31:0] a, input logic wr,
                         input logic [31:0] wd, input logic [3:0] st, input bit last);
    int i;
    psel[p] = 1'b1; penable[p] = 1'b0; paddr[p] = a; pwrite[p] = wr;
    pwdata[p] = wd; pstrb[p] = st; pprot[p] = prot_of(p);
    @(posedge clock); #2;
    penable[p] = 1'b1;
    for (i = 0; i < 300; i++) begin
      @(negedge clock);
      if (pready[p]) break;
    end
    if (i == 300) chk($sformatf("timeout_port%0d", p), 64'(pready[p]), 64'd1);
    @(posedge clock); #2;
    if (last) begin
      psel[p] = 1'b0; penable[p] = 1'b0;
    end
  endtask

  // Downstream SDRAM wrapper model: responds after the queued wait count.
  always begin
    @(posedge clock); #1;
    if (reset_n && out_psel && out_penable && sb.size() != 0) begin
      if (wcnt >= sb[0].waits) begin
        out_pready = 1'b1; out_prdata = sb[0].rdata; out_pslverr = sb[0].err;
      end else begin
        out_pready = 1'b0; wcnt++;
      end
    end else begin
      out_pready = 1'b0; out_pslverr = 1'b0; wcnt = 0;
    end
  end

  // Monitor / scoreboard
  always @(negedge clock) begin
    if (reset_n) begin
      if (out_psel && out_penable && out_pready) begin
        if (sb.size() == 0) begin
          chk("unexpected_completion", 64'(out_paddr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          mon_e = sb.pop_front();
          n_done++;
          chk("grant_port_pready", 64'(pready), (mon_e.port == 1) ? 64'd2 : 64'd1);
          chk("out_paddr",  64'(out_paddr),  64'(mon_e.addr));
          chk("out_pprot",  64'(out_pprot),  64'(mon_e.prot));
          chk("out_pwrite", 64'(out_pwrite), 64'(mon_e.wr));
          chk("out_pwdata", 64'(out_pwdata), 64'(mon_e.wdata));
          chk("out_pstrb",  64'(out_pstrb),  64'(mon_e.strb));
          chk("in0_prdata", 64'(prdata[0]),  64'(mon_e.rdata));
          chk("in1_prdata", 64'(prdata[1]),  64'(mon_e.rdata));
          chk("pslverr", 64'(pslverr),
              !mon_e.err ? 64'd0 : ((mon_e.port == 1) ? 64'd2 : 64'd1));
        end
      end else begin
        chk("stray_pready",  64'(pready),  64'd0);
        chk("stray_pslverr", 64'(pslverr), 64'd0);
      end
      if (!gap_chk) begin
        gap_armed = 1'b0; idle_run = 0;
      end else if (!out_psel) begin
        idle_run++;
      end else if (!out_penable) begin
        if (gap_armed) chk("idle_gap", 64'(idle_run), 64'd1);
        gap_armed = 1'b1; idle_run = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_done=%0d required=%0d", n_done, 22);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    int i;
    psel = '0; penable = '0; pwrite = '0;
    for (int p = 0; p < 2; p++) begin
      paddr[p] = '0; pprot[p] = '0; pwdata[p] = '0; pstrb[p] = '0;
    end
    repeat (3) @(negedge clock);

    // reset state
    chk("rst_out_psel",    64'(out_psel),    64'd0);
    chk("rst_out_penable", 64'(out_penable), 64'd0);
    chk("rst_out_paddr",   64'(out_paddr),   64'd0);
    chk("rst_out_pwdata",  64'(out_pwdata),  64'd0);
    chk("rst_out_pstrb",   64'(out_pstrb),   64'd0);
    chk("rst_out_pprot",   64'(out_pprot),   64'd0);
    chk("rst_out_pwrite",  64'(out_pwrite),  64'd0);
    chk("rst_pready",      64'(pready),      64'd0);
    chk("rst_pslverr",     64'(pslverr),     64'd0);
    chk("rst_last_grant",  64'(dut.last_grant), 64'd1);
    @(posedge clock); #2; reset_n = 1'b1;
    @(posedge clock); #2;

    // simultaneous after reset: port 0 first, then port 1
    push(0, 32'hA000_0000, 1'b0, 32'h0, 4'hF, 32'h1111_0000, 1'b0, 1);
    push(1, 32'hB000_0040, 1'b1, 32'h1234_5678, 4'h3, 32'h2222_0000, 1'b0, 0);
    fork
      apb_req(0, 32'hA000_0000, 1'b0, 32'h0, 4'hF, 1'b1);
      apb_req(1, 32'hB000_0040, 1'b1, 32'h1234_5678, 4'h3, 1'b1);
    join

    // single read with two wait states
    push(0, 32'hA000_0010, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 2);
    apb_req(0, 32'hA000_0010, 1'b0, 32'h0, 4'hF, 1'b1);

    // error forwarded to port 1 only
    push(1, 32'hB000_0080, 1'b1, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b1, 1);
    apb_req(1, 32'hB000_0080, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b1);

    // continuous contention: strict alternation, one idle cycle per gap
    for (i = 0; i < 8; i++) begin
      push(0, 32'hA100_0000 + 32'(i * 4), 1'b0, 32'h0, 4'hF, 32'h0C00_0000 + 32'(i), 1'b0, 0);
      push(1, 32'hB100_0000 + 32'(i * 4), 1'b1, 32'h0D00_0000 + 32'(i), 4'hF,
           32'h0E00_0000 + 32'(i), 1'b0, 0);
    end
    base = n_done;
    gap_chk = 1'b1;
    fork
      begin
        for (int k = 0; k < 8; k++)
          apb_req(0, 32'hA100_0000 + 32'(k * 4), 1'b0, 32'h0, 4'hF, k == 7);
      end
      begin
        for (int k = 0; k < 8; k++)
          apb_req(1, 32'hB100_0000 + 32'(k * 4), 1'b1, 32'h0D00_0000 + 32'(k), 4'hF, k == 7);
      end
    join
    gap_chk = 1'b0;
    chk("contention_completions", 64'(n_done - base), 64'd16);

    // payload stability: requester address changes after grant
    push(0, 32'hA000_0200, 1'b0, 32'h0, 4'hF, 32'h7777_8888, 1'b0, 3);
    fork
      apb_req(0, 32'hA000_0200, 1'b0, 32'h0, 4'hF, 1'b1);
      begin
        for (int k = 0; k < 50; k++) begin
          @(negedge clock);
          if (out_psel) break;
        end
        paddr[0] = 32'hBAD0_0000;
      end
    join

    // reset during ACCESS: no response queued, so the transfer stalls
    psel[0] = 1'b1; penable[0] = 1'b0; paddr[0] = 32'hA000_0300; pwrite[0] = 1'b0;
    pprot[0] = prot_of(0);
    @(posedge clock); #2; penable[0] = 1'b1;
    for (i = 0; i < 20; i++) begin
      @(negedge clock);
      if (out_penable) break;
    end
    chk("reached_access", 64'(out_penable), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_out_psel",    64'(out_psel),    64'd0);
    chk("async_rst_out_penable", 64'(out_penable), 64'd0);
    chk("async_rst_pready",      64'(pready),      64'd0);
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(posedge clock); #2; reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_state", 64'(dut.state), 64'(ARB_IDLE));
    chk("post_rst_out_paddr", 64'(out_paddr), 64'd0);

    // fresh port 1 request completes normally
    @(posedge clock); #2;
    push(1, 32'hB000_0100, 1'b0, 32'h0, 4'hF, 32'h5A5A_A5A5, 1'b0, 0);
    apb_req(1, 32'hB000_0100, 1'b0, 32'h0, 4'hF, 1'b1);

    repeat (3) @(posedge clock);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    chk("total_completions", 64'(n_done), 64'd22);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_apb_arbiter.md
# sdram_apb_arbiter

Two-port round-robin arbiter that shares the single APB slave port of the SDRAM controller wrapper between two APB requesters: port 0 for the CPU LSU and port 1 for DMA. It sits between the SoC APB crossbar and the SDRAM wrapper. It captures the winning request into registers and replays it downstream as a clean two-phase APB transfer. The response is routed back only to the granted requester.

## Interface

- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width; strobe width is DATA_W/8

- clock  in  1  single clock for all logic
- reset_n  in  1  reset, asynchronous and active-low
- in0_paddr / in1_paddr  in  ADDR_W  requester address
- in0_psel / in1_psel  in  1  requester select
- in0_penable / in1_penable  in  1  requester enable
- in0_pprot / in1_pprot  in  3  protection bits
- in0_pwrite / in1_pwrite  in  1  1 = write
- in0_pwdata / in1_pwdata  in  DATA_W  write data
- in0_pstrb / in1_pstrb  in  DATA_W/8  byte strobes
- in0_pready / in1_pready  out  1  completion strobe to requester
- in0_prdata / in1_prdata  out  DATA_W  read data
- in0_pslverr / in1_pslverr  out  1  error, valid with pready
- out_paddr, out_pprot, out_pwrite, out_pwdata, out_pstrb  out  widths as above  registered request to the SDRAM wrapper
- out_psel / out_penable  out  1  downstream APB phase control
- out_pready  in  1  downstream completion
- out_prdata  in  DATA_W  downstream read data
- out_pslverr  in  1  downstream error

## Operation

- FSM states are ARB_IDLE, ARB_SETUP and ARB_ACCESS.
- **ARB_IDLE:** a requester is pending when its inX_psel=1.
  - If none are pending, remain in ARB_IDLE.
  - If one is pending, grant it.
  - If both are pending, grant the port that is not last_grant.
  - On grant, at the clock edge: capture that port's paddr/pprot/pwrite/pwdata/pstrb into the out_* registers, store grant, and go to ARB_SETUP.
- **ARB_SETUP:** drive out_psel=1 and out_penable=0. Always go to ARB_ACCESS next.
- **ARB_ACCESS:** drive out_psel=1 and out_penable=1. Hold until out_pready=1.
  - In that cycle, assert in{grant}_pready=1 and forward out_pslverr, combinationally from out_pready.
  - At the edge: set last_grant to grant, then go to ARB_IDLE.
- in0_prdata and in1_prdata both equal out_prdata. in0_pslverr and in1_pslverr are 0 unless that port is granted and out_pready=1.
- A non-granted requester sees pready=0 and keeps its request asserted, as APB requires. It wins the next arbitration if the other port re-requests.
- in*_penable is not used for arbitration.
- The out_* payload registers hold their value from capture until the next capture.
- If the granted requester illegally drops psel mid-transfer, the downstream transfer still completes. Its response is discarded and arbitration continues normally.
- last_grant resets to 1, so port 0 wins the first simultaneous request.

## Timing

- **Reset:** assertion is asynchronous and immediate. State becomes ARB_IDLE, last_grant=1, and all out_* outputs and registered fields are 0. in*_pready=0 and in*_pslverr=0.
- **Reset mid-transfer:** reset during ARB_SETUP or ARB_ACCESS drops out_psel the same instant and abandons the transfer. The SDRAM wrapper shares the same system reset.
- **Request latency:** if psel is seen in ARB_IDLE at cycle N, out_psel=1 at N+1 and out_penable=1 at N+2.
  - The earliest requester pready is at N+2, when the downstream is zero-wait.
  - The minimum requester-visible latency is 3 cycles, counting the requester's own setup cycle.
- **Back-to-back:** one ARB_IDLE cycle separates consecutive downstream transfers. Peak downstream utilisation is therefore one transfer per 3 cycles plus wait states.
- **Fairness:** with both ports requesting continuously, grants alternate strictly 0,1,0,1.
- A request arriving in the same cycle that the other port completes is arbitrated in the following ARB_IDLE cycle.

## Structure

- Package sdram_arb_pkg contains:
  - typedef enum logic [1:0] arb_state_t: ARB_IDLE, ARB_SETUP, ARB_ACCESS.
  - Constants PORT_CPU=0 and PORT_DMA=1.
- Sub-module rr_arbiter2 is a pure picker. It takes req[1:0] and last_grant and outputs grant_valid and grant_idx. It has no state; the last_grant register lives in the top level.
- Target is roughly 150–200 lines of RTL.

## Test plan

- **Single read:** port 0 reads 0xA000_0010, downstream returns 0xDEADBEEF with 2 wait states. Required: in0_pready pulses exactly once with in0_prdata=0xDEADBEEF, in1_pready stays 0, and out_paddr=0xA000_0010.
- **Simultaneous after reset:** both ports request in the same cycle. Required: port 0 is served first, then port 1. Port 1's write data 0x1234_5678 with strobe 0x3 appears unchanged on out_pwdata and out_pstrb.
- **Continuous contention:** both ports issue 8 back-to-back requests each. Required: grant order 0,1,0,1…, 16 completions in total, and exactly one ARB_IDLE cycle between transfers.
- **Error forwarding:** out_pslverr=1 on a port 1 write. Required: in1_pslverr=1 only in the in1_pready cycle, and in0_pslverr stays 0.
- **Reset mid-operation:** reset_n is pulled low during ARB_ACCESS. Required: out_psel=0 and out_penable=0 without waiting for a clock edge, and the FSM is in ARB_IDLE after release. A new port 1 request then completes normally.
- **Payload stability:** port 0 changes in0_paddr after its transfer is granted (a protocol violation). Required: out_paddr keeps the value captured at grant until the transfer completes.
